rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port instruction/constant ROM (cs/address/ready/data handshake).
- Shares the ROM between the CPU fetch port (port F) and the data/load port (port D); LDE-style table reads are the main source of port D traffic.
- Runs the ROM handshake: cs, then wait for ready low, then wait for ready high.
- Captures read data and returns it to the winner as a one-cycle valid pulse.
- Also handles out-of-range addresses and ROM hang timeout.

Parameters:
- ADDR_W, 16: requester and ROM address width.
- DATA_W, 16: data width.
- ROM_DEPTH, 4096: words implemented; addresses >= ROM_DEPTH are rejected.
- TIMEOUT, 15: maximum cycles spent in WAIT_LOW plus WAIT_HIGH before abort.
- RR_EN, 1: 1 = round-robin between F and D; 0 = fixed priority, F wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held high until f_valid.
- f_addr  in  ADDR_W  fetch word address.
- f_valid  out  1  one-cycle pulse; f_rdata/f_err valid.
- f_rdata  out  DATA_W  fetch read data.
- f_err  out  1  qualifies f_valid: range error or timeout.
- d_req, d_addr, d_valid, d_rdata, d_err: same as the F port, for the data port.
- rom_cs  out  1  chip select to ROM.
- rom_address  out  ADDR_W  address to ROM.
- rom_ready  in  1  ROM ready.
- rom_data  in  DATA_W  ROM data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rom_cs=0; rom_address=0.
  - All valid and err outputs 0; rdata registers 0.
  - last_grant=D, so F wins the first tie.
  - Timeout counter 0.
  - Asserting reset mid-transaction aborts it silently; no valid pulse is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE:
  - If any req, pick a winner:
    - RR_EN=1, both requesting: grant the port not equal to last_grant.
    - RR_EN=0, both requesting: F wins.
    - Only one requesting: that port wins.
  - Latch the winner's address and id; update last_grant.
  - Address >= ROM_DEPTH: go to DONE with err=1, rdata=0; the ROM is not touched.
  - Otherwise: rom_cs<=1, rom_address<=addr, go to ISSUE.
- ISSUE (1 cycle):
  - rom_cs<=0, since the ROM samples cs on exactly one edge.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Stay until rom_ready==0, then go to WAIT_HIGH.
  - The ROM idles with ready=1, so a high ready here is never taken as completion.
- WAIT_HIGH:
  - When rom_ready==1, capture rom_data into the winner's rdata register and go to DONE with err=0.
- rom_address stays stable from ISSUE through WAIT_HIGH.
- Timeout:
  - The counter increments in WAIT_LOW and WAIT_HIGH and clears in IDLE.
  - On reaching TIMEOUT: go to DONE with err=1, rdata=0.
- DONE (1 cycle):
  - Winner's valid=1, plus its err and rdata; the other port's valid stays 0.
  - Next state is IDLE.
  - rdata holds its value until the next completion for that port.
- Back-to-back requests: the requester drops req on the cycle after valid. A req still high in IDLE is treated as a new request.
- Nominal latency with the standard 3-state ROM: req sampled at edge N, valid high after edge N+5.
  - N: IDLE to ISSUE.
  - N+1: ROM state 1.
  - N+2: WAIT_LOW sees ready=0.
  - N+3: ROM state 2, data valid.
  - N+4: WAIT_HIGH captures.
  - N+5: DONE.
- A req that arrives while busy is ignored until IDLE; no queuing.
- A req deasserted before grant is simply not granted. Deassertion after grant is ignored; the transaction still completes and pulses valid.

Decomposition:
- Package rom_arb_pkg:
  - State enum: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
  - Requester id constants: ID_F=0, ID_D=1.
  - Default ROM_DEPTH and TIMEOUT localparams.
- One natural sub-module: rom_arb_pick, the combinational winner selection from f_req, d_req, last_grant and RR_EN.
- The FSM, address range check and timeout counter stay in rom_arbiter.

Test Plan:
- Single F read, f_addr=0x0001, ROM word 1 = 0x0001: f_valid pulses 5 cycles after req; f_rdata=0x0001, f_err=0; d_valid stays 0.
- F and D request together, addresses 0x0002 and 0x0003, RR_EN=1:
  - F served first, then D, then F again on the next tie.
  - d_rdata equals ROM word 3.
  - rom_cs is never high for more than 1 cycle.
- d_addr=0x1000 (ROM_DEPTH=4096): d_valid with d_err=1 and d_rdata=0, 2 cycles after req; rom_cs never asserted.
- ROM model that never drops ready after cs: abort after TIMEOUT=15 cycles with f_err=1; FSM returns to IDLE and the next request completes normally.
- rst_n pulled low during WAIT_HIGH: all outputs 0 immediately (async); no valid pulse afterwards; after release, F wins the first tie.
- RR_EN=0 with both ports held requesting continuously: F is granted every time and D starves. This starvation is the required behaviour; the bench checks D gets no grant across 10 transactions.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter: FSM states, requester ids
// and the default ROM geometry / hang timeout.
package rom_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    localparam logic ID_F = 1'b0;
    localparam logic ID_D = 1'b1;

    localparam int DEFAULT_ROM_DEPTH = 4096;
    localparam int DEFAULT_TIMEOUT   = 15;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection between the fetch (F) and data (D) ports.
// With RR_EN set, a tie goes to the port that did not win last time;
// otherwise F always wins a tie.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic f_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winner for this cycle from the live requests and grant history
    always_comb begin
        grant_valid = f_req | d_req;
        grant_id    = ID_F;
        if (f_req && d_req) begin
            if ((RR_EN != 0) && (last_grant == ID_F)) begin
                grant_id = ID_D;
            end
        end else if (d_req) begin
            grant_id = ID_D;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port ROM. Runs the
// cs / ready-low / ready-high handshake for the winning port, rejects
// out-of-range addresses without touching the ROM, aborts a hung ROM after
// TIMEOUT wait cycles, and returns the result as a one-cycle valid pulse.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int RR_EN     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              rom_cs,
    output logic [ADDR_W-1:0] rom_address,
    input  logic              rom_ready,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(TIMEOUT);
    localparam logic [ADDR_W:0]   DEPTH_LIMIT = (ADDR_W + 1)'(ROM_DEPTH);

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic              err_pend_q, err_pend_d;
    logic              rom_cs_q, rom_cs_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic              f_valid_q, f_valid_d;
    logic              f_err_q, f_err_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              grant_valid;
    logic              grant_id;
    logic [ADDR_W-1:0] grant_addr;
    logic              addr_ok;
    logic [TMO_W-1:0]  tmo_inc;

    rom_arb_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign grant_addr = (grant_id == ID_D) ? d_addr : f_addr;
    assign addr_ok    = ({1'b0, grant_addr} < DEPTH_LIMIT);
    assign tmo_inc    = tmo_q + 1'b1;

    // Next-state, handshake and result logic; valid/err pulse only out of DONE
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        last_grant_d  = last_grant_q;
        err_pend_d    = err_pend_q;
        rom_cs_d      = rom_cs_q;
        rom_address_d = rom_address_q;
        tmo_d         = tmo_q;
        f_rdata_d     = f_rdata_q;
        d_rdata_d     = d_rdata_q;
        f_valid_d     = 1'b0;
        f_err_d       = 1'b0;
        d_valid_d     = 1'b0;
        d_err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (grant_valid) begin
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    if (addr_ok) begin
                        err_pend_d    = 1'b0;
                        rom_cs_d      = 1'b1;
                        rom_address_d = grant_addr;
                        state_d       = ISSUE;
                    end else begin
                        err_pend_d = 1'b1;
                        if (grant_id == ID_F) f_rdata_d = '0;
                        else                  d_rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                rom_cs_d = 1'b0;
                state_d  = WAIT_LOW;
            end
            WAIT_LOW: begin
                tmo_d = tmo_inc;
                if (tmo_inc >= TMO_LIMIT) begin
                    err_pend_d = 1'b1;
                    if (id_q == ID_F) f_rdata_d = '0;
                    else              d_rdata_d = '0;
                    state_d = DONE;
                end else if (!rom_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                tmo_d = tmo_inc;
                if (rom_ready) begin
                    err_pend_d = 1'b0;
                    if (id_q == ID_F) f_rdata_d = rom_data;
                    else              d_rdata_d = rom_data;
                    state_d = DONE;
                end else if (tmo_inc >= TMO_LIMIT) begin
                    err_pend_d = 1'b1;
                    if (id_q == ID_F) f_rdata_d = '0;
                    else              d_rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                f_valid_d  = (id_q == ID_F);
                f_err_d    = (id_q == ID_F) && err_pend_q;
                d_valid_d  = (id_q == ID_D);
                d_err_d    = (id_q == ID_D) && err_pend_q;
                err_pend_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            id_q          <= ID_F;
            last_grant_q  <= ID_D;
            err_pend_q    <= 1'b0;
            rom_cs_q      <= 1'b0;
            rom_address_q <= '0;
            tmo_q         <= '0;
            busy_q        <= 1'b0;
            f_valid_q     <= 1'b0;
            f_err_q       <= 1'b0;
            f_rdata_q     <= '0;
            d_valid_q     <= 1'b0;
            d_err_q       <= 1'b0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            last_grant_q  <= last_grant_d;
            err_pend_q    <= err_pend_d;
            rom_cs_q      <= rom_cs_d;
            rom_address_q <= rom_address_d;
            tmo_q         <= tmo_d;
            busy_q        <= busy_d;
            f_valid_q     <= f_valid_d;
            f_err_q       <= f_err_d;
            f_rdata_q     <= f_rdata_d;
            d_valid_q     <= d_valid_d;
            d_err_q       <= d_err_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign f_valid     = f_valid_q;
    assign f_err       = f_err_q;
    assign f_rdata     = f_rdata_q;
    assign d_valid     = d_valid_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign rom_cs      = rom_cs_q;
    assign rom_address = rom_address_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a 3-state ROM model, a response scoreboard fed by
// the stimulus and drained by a monitor, plus a fixed-priority instance used
// to show D starving when F never lets go.
`timescale 1ns/1ps
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_valid;
    logic [15:0] f_rdata;
    logic        f_err;
    logic        d_req = 1'b0;
    logic [15:0] d_addr = '0;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        rom_cs;
    logic [15:0] rom_address;
    logic        rom_ready;
    logic [15:0] rom_data;
    logic        busy;

    logic        fp_f_req = 1'b0;
    logic [15:0] fp_f_addr = '0;
    logic        fp_f_valid;
    logic [15:0] fp_f_rdata;
    logic        fp_f_err;
    logic        fp_d_req = 1'b0;
    logic [15:0] fp_d_addr = '0;
    logic        fp_d_valid;
    logic [15:0] fp_d_rdata;
    logic        fp_d_err;
    logic        fp_rom_cs;
    logic [15:0] fp_rom_address;
    logic        fp_rom_ready = 1'b1;
    logic [15:0] fp_rom_data = '0;
    logic        fp_busy;

    rom_arbiter #(
        .ADDR_W(16), .DATA_W(16), .ROM_DEPTH(4096), .TIMEOUT(15), .RR_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .rom_cs(rom_cs), .rom_address(rom_address), .rom_ready(rom_ready), .rom_data(rom_data),
        .busy(busy)
    );

    rom_arbiter #(
        .ADDR_W(16), .DATA_W(16), .ROM_DEPTH(4096), .TIMEOUT(15), .RR_EN(0)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .f_req(fp_f_req), .f_addr(fp_f_addr), .f_valid(fp_f_valid), .f_rdata(fp_f_rdata), .f_err(fp_f_err),
        .d_req(fp_d_req), .d_addr(fp_d_addr), .d_valid(fp_d_valid), .d_rdata(fp_d_rdata), .d_err(fp_d_err),
        .rom_cs(fp_rom_cs), .rom_address(fp_rom_address), .rom_ready(fp_rom_ready), .rom_data(fp_rom_data),
        .busy(fp_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cs_count = 0;
    logic prev_cs = 1'b0;
    logic rom_hang = 1'b0;
    logic [1:0] rom_phase;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    // ROM contents: word a holds a*a, so word 1 = 0x0001, 2 = 0x0004, 3 = 0x0009
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return a * a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectResp(input logic port, input logic err, input logic [15:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Drives requests immediately; callers are always sitting on a negedge
    task automatic applyStimulus(input logic fr, input logic [15:0] fa, input logic dr, input logic [15:0] da);
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
    endtask

    // Counts negedges until the chosen port's valid is seen (bounded)
    task automatic waitValid(input logic port, input string name, output int edges);
        logic seen;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 100) begin
            @(negedge clk);
            edges++;
            seen = port ? d_valid : f_valid;
        end
        checkOutput({name, "_seen"}, {31'b0, seen}, 32'd1);
    endtask

    // Standard ROM: cs seen -> ready low for two edges -> ready high with data
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ready <= 1'b1;
            rom_data  <= '0;
            rom_phase <= 2'd0;
        end else begin
            case (rom_phase)
                2'd0: if (rom_cs && !rom_hang) begin
                    rom_ready <= 1'b0;
                    rom_phase <= 2'd1;
                end
                2'd1: rom_phase <= 2'd2;
                default: begin
                    rom_ready <= 1'b1;
                    rom_data  <= rom_word(rom_address);
                    rom_phase <= 2'd0;
                end
            endcase
        end
    end

    // Monitor: cs width, and every valid pulse popped against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rom_cs) begin
                cs_count++;
                checkOutput("rom_cs_width", {31'b0, prev_cs}, 32'd0);
            end
            prev_cs = rom_cs;
            if (f_valid || d_valid) begin
                checkOutput("both_valid", {31'b0, f_valid & d_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", {30'b0, f_valid, d_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("grant_port", {31'b0, d_valid}, {31'b0, e.port});
                    checkOutput("resp_err", {31'b0, d_valid ? d_err : f_err}, {31'b0, e.err});
                    checkOutput("resp_rdata", {16'b0, d_valid ? d_rdata : f_rdata}, {16'b0, e.rdata});
                end
            end
        end else begin
            prev_cs = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int cs_before;
        int f_cnt;
        int d_cnt;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_valids", {30'b0, f_valid, d_valid}, 32'd0);
        checkOutput("reset_errs", {30'b0, f_err, d_err}, 32'd0);
        checkOutput("reset_rdata", {f_rdata, d_rdata}, 32'd0);
        checkOutput("reset_rom", {15'b0, rom_cs, rom_address}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single F read of word 1: valid visible after sampling edge + 5
        expectResp(1'b0, 1'b0, 16'h0001);
        applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0000);
        waitValid(1'b0, "single_f", edges);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("single_f_latency", edges, 32'd6);

        // D out of range: straight to DONE, ROM untouched, valid after edge + 1
        @(negedge clk);
        cs_before = cs_count;
        expectResp(1'b1, 1'b1, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h1000);
        waitValid(1'b1, "range_d", edges);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("range_latency", edges, 32'd2);
        checkOutput("range_no_cs", cs_count, cs_before);

        // Hung ROM: IDLE, ISSUE, 15 wait cycles, DONE -> valid after edge + 17
        @(negedge clk);
        rom_hang = 1'b1;
        expectResp(1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h0005, 1'b0, 16'h0000);
        waitValid(1'b0, "timeout_f", edges);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        rom_hang = 1'b0;
        checkOutput("timeout_latency", edges, 32'd18);
        checkOutput("timeout_idle", {31'b0, busy}, 32'd0);

        // Normal read right after the abort
        @(negedge clk);
        expectResp(1'b0, 1'b0, 16'd36);
        applyStimulus(1'b1, 16'h0006, 1'b0, 16'h0000);
        waitValid(1'b0, "recover_f", edges);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("recover_latency", edges, 32'd6);

        // Reset during WAIT_HIGH (entered at sampling edge + 2)
        @(negedge clk);
        applyStimulus(1'b1, 16'h0007, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("hold_f_rdata", {16'b0, f_rdata}, 32'd36);
        checkOutput("stable_address", {16'b0, rom_address}, 32'h0007);
        checkOutput("busy_in_wait", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_valids", {30'b0, f_valid, d_valid}, 32'd0);
        checkOutput("async_rdata", {f_rdata, d_rdata}, 32'd0);
        checkOutput("async_rom", {15'b0, rom_cs, rom_address}, 32'd0);
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Round-robin ties after reset: F, then D, then F again
        expectResp(1'b0, 1'b0, 16'h0004);
        expectResp(1'b1, 1'b0, 16'h0009);
        expectResp(1'b0, 1'b0, 16'h0004);
        applyStimulus(1'b1, 16'h0002, 1'b1, 16'h0003);
        waitValid(1'b0, "tie_first_f", edges);
        applyStimulus(1'b0, 16'h0002, 1'b1, 16'h0003);
        waitValid(1'b1, "tie_then_d", edges);
        applyStimulus(1'b1, 16'h0002, 1'b1, 16'h0003);
        waitValid(1'b0, "tie_again_f", edges);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

        // Fixed priority with both held: F every time, D never granted
        fp_f_addr = 16'h2000;
        fp_d_addr = 16'h0010;
        fp_f_req  = 1'b1;
        fp_d_req  = 1'b1;
        f_cnt = 0;
        d_cnt = 0;
        for (int i = 0; i < 200 && f_cnt < 10; i++) begin
            @(negedge clk);
            if (fp_f_valid) begin
                f_cnt++;
                checkOutput("fp_f_err", {31'b0, fp_f_err}, 32'd1);
            end
            if (fp_d_valid) d_cnt++;
        end
        fp_f_req = 1'b0;
        fp_d_req = 1'b0;
        checkOutput("fp_f_grants", f_cnt, 32'd10);
        checkOutput("fp_d_starved", d_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
